// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared definitions for the sync_fifo block.
//   count_width()  - width of the occupancy counter, clog2(DEPTH)+1 so DEPTH itself fits.
//   is_pow2()      - power-of-two test used by the parameter checks.
//   params_legal() - full legality check of the FIFO parameter set; evaluated at elaboration.
//   read_mode_e    - standard vs first-word-fall-through read behaviour.
package sync_fifo_pkg;

    typedef enum logic {
        ReadStd,
        ReadFwft
    } read_mode_e;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int unsigned width,
                                        input int unsigned depth,
                                        input int unsigned fwft,
                                        input int unsigned af_offset,
                                        input int unsigned ae_offset);
        return (width >= 1) && (width <= 72) &&
               is_pow2(depth) && (depth >= 4) &&
               (fwft <= 1) &&
               (af_offset >= 1) && (af_offset <= depth - 1) &&
               (ae_offset >= 1) && (ae_offset <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM, one write port and one synchronous read port with read enable.
// The storage array has no reset so it infers as block RAM / SRAM; only the read-data register
// is cleared so the FIFO output comes up at zero.
//   clk   - clock
//   rst   - synchronous active-high reset of the read-data register only
//   we    - write enable; wdata is stored at waddr
//   re    - read enable; rdata loads mem[raddr] on the edge, otherwise holds
//   rdata - registered read data
module fifo_ram #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 512,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with standard or first-word-fall-through read mode.
//   clk, rst          - clock and synchronous active-high reset
//   din, wr_en        - write data / request (accepted when !full)
//   rd_en             - read request; in FWFT mode, pop of the word shown on dout
//   dout              - read data
//   full, empty       - count == DEPTH / no word readable
//   almostfull        - count >= DEPTH - AF_OFFSET
//   almostempty       - count <= AE_OFFSET
//   count             - words held, including the FWFT output stage
//   wrerr, rderr      - one-cycle pulses after a write while full / read while empty
// All flags are registered and computed from next-state count so they change on the same edge
// as the operation that causes them.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 9,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AF_OFFSET = 128,
    parameter int unsigned AE_OFFSET = 128,
    localparam int unsigned CW = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almostfull,
    output logic             almostempty,
    output logic [CW-1:0]    count,
    output logic             wrerr,
    output logic             rderr
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);
    localparam logic [CW-1:0] AfLevel   = CW'(DEPTH - AF_OFFSET);
    localparam logic [CW-1:0] AeLevel   = CW'(AE_OFFSET);
    localparam read_mode_e    Mode      = (FWFT != 0) ? ReadFwft : ReadStd;
    localparam bit            Fwft      = (Mode == ReadFwft);

    if (!params_legal(WIDTH, DEPTH, FWFT, AF_OFFSET, AE_OFFSET)) begin : g_bad_params
        $error("sync_fifo: illegal parameter set");
    end

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q, af_q, ae_q, wrerr_q, rderr_q;
    logic             ov_q, ov_d;        // FWFT output stage holds a valid word
    logic             sel_q;             // dout sourced from bypass register instead of RAM
    logic [WIDTH-1:0] byp_q;
    logic [WIDTH-1:0] ram_rdata;

    logic             wr_acc, rd_acc;
    logic             ram_re, bypass, ram_has;
    logic [CW-1:0]    ram_words;
    logic             empty_d;

    // Acceptance uses the registered (pre-edge) flags: no bypass of full/empty.
    assign wr_acc = wr_en && !full_q && !rst;
    assign rd_acc = rd_en && !empty_q && !rst;

    // Words still in RAM, i.e. not yet moved into the FWFT output stage.
    assign ram_words = count_q - CW'(ov_q);
    assign ram_has   = (ram_words != '0);

    // FWFT prefetches whenever the output stage is empty or being popped. When a pop and a
    // write coincide with nothing left in RAM, the written word goes straight to the output
    // stage so a single-word FIFO still sustains one read and one write per cycle.
    assign ram_re = Fwft ? (!rst && ram_has && (!ov_q || rd_acc)) : rd_acc;
    assign bypass = Fwft && rd_acc && wr_acc && !ram_has;

    always_comb begin
        ov_d = ov_q;
        if (!Fwft) begin
            ov_d = 1'b0;
        end else if (ram_re || bypass) begin
            ov_d = 1'b1;
        end else if (rd_acc) begin
            ov_d = 1'b0;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign empty_d = Fwft ? !ov_d : (count_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            wrerr_q  <= 1'b0;
            rderr_q  <= 1'b0;
            ov_q     <= 1'b0;
            sel_q    <= 1'b0;
            byp_q    <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            // A bypass consumes the RAM slot that was written in the same cycle.
            if (ram_re || bypass) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CountFull);
            empty_q <= empty_d;
            af_q    <= (count_d >= AfLevel);
            ae_q    <= (count_d <= AeLevel);
            wrerr_q <= wr_en && full_q;
            rderr_q <= rd_en && empty_q;
            ov_q    <= ov_d;
            if (bypass) begin
                byp_q <= din;
                sel_q <= 1'b1;
            end else if (ram_re) begin
                sel_q <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign dout        = sel_q ? byp_q : ram_rdata;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almostfull  = af_q;
    assign almostempty = ae_q;
    assign count       = count_q;
    assign wrerr       = wrerr_q;
    assign rderr       = rderr_q;

endmodule
